aud_player: RTL

AUD_PLAYER -- requirements
Module: aud_player

---
 rtl/aud_player_pkg.sv | 15 +
 rtl/aud_player_if.sv | 28 ++
 rtl/aud_shift_tx.sv | 46 ++++
 rtl/aud_player.sv | 125 ++++++++++++
 4 files changed

// File: rtl/aud_player_pkg.sv
// Definitions shared by the audio player and the audio recorder:
// the sample and address widths, and the playback state encoding.
package aud_player_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SEND,
      S_GAP
   } state_t;

endpackage

// File: rtl/aud_player_if.sv
// Control, SRAM and DAC signals of the audio player, grouped into one bus.
// The master drives the controls and the SRAM data; the player (slave) drives the rest.
interface aud_player_if #(
   parameter int DATA_W = aud_player_pkg::DATA_W,
   parameter int ADDR_W = aud_player_pkg::ADDR_W
) ();

   logic              i_lrc;
   logic              i_start;
   logic              i_pause;
   logic              i_stop;
   logic [ADDR_W-1:0] i_end_addr;
   logic [DATA_W-1:0] i_data;
   logic [ADDR_W-1:0] o_address;
   logic              o_dac_data;
   logic              o_done;

   modport master (
      output i_lrc, i_start, i_pause, i_stop, i_end_addr, i_data,
      input  o_address, o_dac_data, o_done
   );

   modport slave (
      input  i_lrc, i_start, i_pause, i_stop, i_end_addr, i_data,
      output o_address, o_dac_data, o_done
   );

endinterface

// File: rtl/aud_shift_tx.sv
// Parallel-load, MSB-first serialiser with a bit counter; the serial output is
// registered and falls to zero in any cycle that neither loads nor shifts.
module aud_shift_tx #(
   parameter int DATA_W = aud_player_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              bit_out,
   output logic              last
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-2:0] shreg;
   logic [CNT_W-1:0]  count;

   // The counter reaches zero while bit 1 is on the wire, so the shift that puts
   // bit 0 out is the one that sees last high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_out <= 1'b0;
         shreg   <= '0;
         count   <= '0;
      end else if (load) begin
         bit_out <= din[DATA_W-1];
         shreg   <= din[DATA_W-2:0];
         count   <= CNT_W'(DATA_W - 2);
      end else if (shift) begin
         bit_out <= shreg[DATA_W-2];
         shreg   <= {shreg[DATA_W-3:0], 1'b0};
         if (count != '0) begin
            count <= count - 1'b1;
         end
      end else begin
         bit_out <= 1'b0;
         shreg   <= '0;
         count   <= '0;
      end
   end

   assign last = (count == '0);

endmodule

// File: rtl/aud_player.sv
// I2S audio player: reads samples from SRAM and sends each one MSB first on both
// channels of a frame, with a one-BCLK delay after each LRC edge.
module aud_player #(
   parameter int DATA_W = aud_player_pkg::DATA_W,
   parameter int ADDR_W = aud_player_pkg::ADDR_W
) (
   input logic         i_clk,
   input logic         i_rst_n,
   aud_player_if.slave bus
);

   import aud_player_pkg::*;

   state_t            state;
   logic              lrc_d;
   logic              mute;
   logic              last;
   logic              left;
   logic              done;
   logic [DATA_W-1:0] hold;
   logic [ADDR_W-1:0] address;

   logic              rise;
   logic              fall;
   logic              stop_evt;
   logic              frame_evt;
   logic              fall_evt;
   logic              word_end;
   logic              advance;
   logic              tx_load;
   logic              tx_shift;
   logic              tx_last;
   logic              tx_bit;
   logic [DATA_W-1:0] new_word;
   logic [DATA_W-1:0] tx_din;

   // An LRC edge seen during SEND truncates the word in flight, and the left word
   // still counts as played so that short half-frames keep the address moving.
   always_comb begin
      rise      = bus.i_lrc && !lrc_d;
      fall      = !bus.i_lrc && lrc_d;
      stop_evt  = (state != S_IDLE) && bus.i_stop;
      frame_evt = !stop_evt && rise && (state != S_IDLE);
      fall_evt  = !stop_evt && fall && (state == S_SEND || state == S_GAP);
      tx_shift  = !stop_evt && !rise && !fall && (state == S_SEND);
      word_end  = tx_shift && tx_last;
      advance   = (state == S_SEND) && left && !mute && (fall_evt || word_end);
      new_word  = bus.i_pause ? '0 : bus.i_data;
      tx_load   = (frame_evt && !last) || fall_evt;
      tx_din    = frame_evt ? new_word : hold;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         lrc_d   <= 1'b0;
         mute    <= 1'b0;
         last    <= 1'b0;
         left    <= 1'b0;
         done    <= 1'b0;
         hold    <= '0;
         address <= '0;
      end else begin
         lrc_d <= bus.i_lrc;
         done  <= 1'b0;
         if (stop_evt) begin
            state   <= S_IDLE;
            address <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.i_start && !bus.i_stop) begin
                     address <= '0;
                     last    <= 1'b0;
                     state   <= S_WAIT;
                  end
               end
               default: begin
                  if (frame_evt) begin
                     mute <= bus.i_pause;
                     if (last) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        hold  <= new_word;
                        left  <= 1'b1;
                        state <= S_SEND;
                     end
                  end else if (fall_evt) begin
                     left  <= 1'b0;
                     state <= S_SEND;
                  end else if (word_end) begin
                     state <= S_GAP;
                  end
               end
            endcase
            // The final address is played once and then flagged rather than passed.
            if (advance) begin
               if (address == bus.i_end_addr) begin
                  last <= 1'b1;
               end else begin
                  address <= address + 1'b1;
               end
            end
         end
      end
   end

   aud_shift_tx #(
      .DATA_W(DATA_W)
   ) u_tx (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .load   (tx_load),
      .shift  (tx_shift),
      .din    (tx_din),
      .bit_out(tx_bit),
      .last   (tx_last)
   );

   assign bus.o_address  = address;
   assign bus.o_dac_data = tx_bit;
   assign bus.o_done     = done;

endmodule
